// File: rtl/opti_sos_ctrl.sv
// Sequencing / configuration controller for a cascade of transposed-II SOS
// sections in Q2.22. Holds a shadow and an active coefficient bank with an
// atomic shadow->active commit, issues one sample at a time into the cascade,
// waits for the last stage (with a timeout watchdog) and returns the result.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid is held with stable data until that edge, and ready never depends
// combinationally on the same interface's valid (s_ready is a function of
// registered state only).
module opti_sos_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  input  logic [23:0]               s_data,
  output logic                      s_ready,
  output logic                      m_valid,
  output logic [23:0]               m_data,
  input  logic                      m_ready,
  input  logic                      cfg_we,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [23:0]               cfg_wdata,
  input  logic                      cfg_commit,
  output logic                      commit_pend,
  output logic                      sos_valid_in,
  output logic [23:0]               sos_data_in,
  input  logic                      sos_valid_out,
  input  logic [23:0]               sos_data_out,
  output logic [24*NUM_STAGES-1:0]  coef_b0,
  output logic [24*NUM_STAGES-1:0]  coef_b1,
  output logic [24*NUM_STAGES-1:0]  coef_b2,
  output logic [24*NUM_STAGES-1:0]  coef_a1,
  output logic [24*NUM_STAGES-1:0]  coef_a2,
  output logic                      err_timeout,
  output logic                      err_cfg,
  input  logic                      err_clr,
  output logic [1:0]                dbg_state
);

  localparam int SW = ADDR_W - 3;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [23:0] ONE_Q222 = 24'h400000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic [23:0]       sample;

  // Bank layout: [stage][idx], idx 0..4 = b0, b1, b2, a1, a2
  logic [23:0]       sh_bank  [NUM_STAGES][5];
  logic [23:0]       act_bank [NUM_STAGES][5];

  logic [SW-1:0]     wr_stage;
  logic [2:0]        wr_idx;
  logic              wr_ok;
  logic              do_copy;
  logic              accept;
  logic              wait_hit;
  logic              wait_expire;

  assign wr_stage    = cfg_addr[ADDR_W-1:3];
  assign wr_idx      = cfg_addr[2:0];
  assign wr_ok       = (int'(wr_stage) < NUM_STAGES) && (wr_idx <= 3'd4);
  assign wait_hit    = (state == WAIT) && sos_valid_out;
  assign wait_expire = (state == WAIT) && !sos_valid_out && (wait_cnt == CW'(TIMEOUT - 1));
  assign dbg_state   = state;
  assign sos_data_in = sample;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a pending commit takes priority over a new sample in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_hit || wait_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and derived strobes
  always_comb begin
    s_ready      = 1'b0;
    sos_valid_in = 1'b0;
    do_copy      = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !commit_pend && !m_valid;
        do_copy = commit_pend;
      end
      ISSUE:   sos_valid_in = 1'b1;
      default: ;
    endcase
    accept = s_valid && s_ready;
  end

  // Sample latch, wait counter, result register, commit flag and sticky errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample      <= '0;
      wait_cnt    <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      commit_pend <= 1'b0;
      err_timeout <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      if (accept) sample <= s_data;

      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;

      if (wait_hit) begin
        m_valid <= 1'b1;
        m_data  <= sos_data_out;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      // A new request in the copy cycle keeps the flag set for another copy
      commit_pend <= cfg_commit || (commit_pend && !do_copy);

      // Setting an error beats clearing it in the same cycle
      if (wait_expire)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      if (cfg_we && !wr_ok) err_cfg <= 1'b1;
      else if (err_clr)     err_cfg <= 1'b0;
    end
  end

  // Coefficient banks: copy reads the old shadow, so a same-cycle write only lands in shadow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        for (int i = 0; i < 5; i++) begin
          sh_bank[k][i]  <= (i == 0) ? ONE_Q222 : 24'h0;
          act_bank[k][i] <= (i == 0) ? ONE_Q222 : 24'h0;
        end
      end
    end else begin
      if (do_copy) act_bank <= sh_bank;
      if (cfg_we && wr_ok) sh_bank[wr_stage][wr_idx] <= cfg_wdata;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_coef
    assign coef_b0[24*k +: 24] = act_bank[k][0];
    assign coef_b1[24*k +: 24] = act_bank[k][1];
    assign coef_b2[24*k +: 24] = act_bank[k][2];
    assign coef_a1[24*k +: 24] = act_bank[k][3];
    assign coef_a2[24*k +: 24] = act_bank[k][4];
  end

endmodule
